fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameters: PC_W, default 16, PC/address width (word-addressed); INSTR_W, default 17, instruction width; RESET_PC, default 0, first fetch address.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge).
REQ-004 SHALL have ports: imem_req_valid  out  1  fetch request; imem_req_ready  in  1  request accepted; imem_req_addr  out  PC_W  fetch address.
REQ-005 SHALL have ports: imem_rsp_valid  in  1  response present; imem_rsp_data  in  INSTR_W  instruction word (in-order responses, no backpressure).
REQ-006 SHALL have ports: redirect_valid  in  1  taken branch/PC write (PCSrc); redirect_pc  in  PC_W  new PC.
REQ-007 SHALL have ports: instr_valid  out  1  instruction available; instr_ready  in  1  decode/controller consumes; instr_out  out  INSTR_W  instruction ([16:11] feeds the controller); instr_pc  out  PC_W  its address.

Function
REQ-008 SHALL contain a fetch PC register (fpc), an in-flight counter (0..3), a drop counter (0..3), a rsp_pc register, and a 3-entry response FIFO.
REQ-009 SHALL implement FSM IDLE->RUN: IDLE one cycle after reset released, no requests; RUN thereafter; no other transitions except reset->IDLE.
REQ-010 SHALL, in RUN, assert imem_req_valid when (inflight + fifo_count) < 3 using registered values only, with imem_req_addr = fpc.
REQ-011 SHALL hold imem_req_addr stable while imem_req_valid && !imem_req_ready, except on redirect.
REQ-012 SHALL, on request handshake (valid && ready), increment inflight and fpc by 1; fpc wraps 2^PC_W-1 -> 0.
REQ-013 SHALL, on imem_rsp_valid, decrement inflight; if drop>0, discard the word and decrement drop; else push {data, rsp_pc} and increment rsp_pc (wrapping).
REQ-014 SHALL present FIFO head on instr_out/instr_pc with instr_valid = !empty; pop on instr_valid && instr_ready; push and pop in the same cycle both take effect.
REQ-015 SHALL, on redirect_valid: flush FIFO; set fpc and rsp_pc to redirect_pc; set drop = inflight after this cycle's response and handshake accounting; withdraw any unaccepted request.
REQ-016 SHALL give redirect priority: same-cycle response is counted as dropped or flushed, same-cycle pop is ignored, and same-cycle request handshake is counted into drop.
REQ-017 SHALL issue the first request at redirect_pc in the cycle after redirect_valid, subject to REQ-010.
REQ-018 SHALL sustain one instruction per cycle with 1-cycle memory latency and instr_ready held high.
REQ-019 SHALL never overflow the FIFO; FIFO-full with pending responses is impossible by REQ-010.
REQ-020 SHALL ignore imem_rsp_valid when inflight==0; this condition is an assertion failure in verification.

Reset
REQ-021 SHALL, while reset==0, drive imem_req_valid=0, instr_valid=0, instr_out=0, instr_pc=0, imem_req_addr=RESET_PC.
REQ-022 SHALL reset fpc=RESET_PC, rsp_pc=RESET_PC, inflight=0, drop=0, FIFO empty, state=IDLE.
REQ-023 SHALL abandon in-flight requests on reset; responses arriving while reset==0 are discarded.

Structure
REQ-024 SHALL place PC_W, INSTR_W, RESET_PC defaults, the FIFO depth (3), and the state enum {IDLE, RUN} in shared package fetch_pkg.
REQ-025 SHALL implement the buffer as sub-module fetch_fifo (depth 3, width INSTR_W+PC_W, push/pop/flush, count output).

Verification
REQ-026 Reset release, 1-cycle memory, instr_ready=1 -> addr 0,1,2,... on consecutive cycles from the 2nd cycle after release; instr_pc 0,1,2 back-to-back.
REQ-027 instr_ready=0 for 10 cycles -> exactly 3 requests accepted, FIFO full, req_valid low; ready=1 -> instructions 0,1,2 in order, no loss.
REQ-028 Redirect to 0x0040 with 2 in flight -> both responses dropped, next request addr 0x0040, first instr_pc=0x0040.
REQ-029 Redirect in same cycle as response and pop -> popped/arriving words discarded, instr_valid=0 next cycle.
REQ-030 fpc=0xFFFF, 2 fetches -> addresses 0xFFFF then 0x0000; instr_pc matches.
REQ-031 reset asserted mid-stream with 3 in flight -> next cycle all outputs at reset values; late responses produce no instr_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, buffer depth and FSM state type for the instruction fetch unit.
// Pure declarations: no latency, no flow control.
// Pointer helper wraps modulo the buffer depth.
package fetch_pkg;

    localparam int PC_W_DFLT     = 16;
    localparam int INSTR_W_DFLT  = 17;
    localparam int RESET_PC_DFLT = 0;
    localparam int FIFO_DEPTH    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Three-entry response buffer holding {instruction, pc} pairs for decode.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: push is dropped when full with no pop; flush beats push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W = INSTR_W_DFLT + PC_W_DFLT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic [1:0]   rd_ptr;
    logic [1:0]   wr_ptr;
    logic         full;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && reset && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order memory requests and buffers responses for decode.
// Latency: first request two cycles after reset release; 1/cycle sustained with 1-cycle memory.
// Backpressure: requests stop once in-flight plus buffered reaches 3; redirect flushes and drops.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          PC_W     = PC_W_DFLT,
    parameter int          INSTR_W  = INSTR_W_DFLT,
    parameter int unsigned RESET_PC = RESET_PC_DFLT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc
);

    localparam int              ENTRY_W = INSTR_W + PC_W;
    localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_PC);

    state_t             state_q;
    state_t             state_d;
    logic [PC_W-1:0]    fpc;
    logic [PC_W-1:0]    rsp_pc;
    logic [1:0]         inflight;
    logic [1:0]         inflight_nxt;
    logic [1:0]         drop;
    logic [1:0]         fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               req_hs;
    logic               rsp_acc;
    logic               push;
    logic               pop;

    // Issue decision looks only at registered counts so it never depends on same-cycle inputs.
    assign imem_req_valid = reset && (state_q == RUN)
                            && ((3'(inflight) + 3'(fifo_count)) < 3'(FIFO_DEPTH));
    assign imem_req_addr  = reset ? fpc : RST_PC;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is stray and must not disturb the counters.
    assign rsp_acc = reset && imem_rsp_valid && (inflight != 2'd0);
    assign push    = rsp_acc && (drop == 2'd0) && !redirect_valid;
    assign pop     = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = reset && !fifo_empty;
    assign instr_out   = instr_valid ? fifo_head[ENTRY_W-1 -: INSTR_W] : '0;
    assign instr_pc    = instr_valid ? fifo_head[PC_W-1:0] : '0;

    always_comb begin
        case ({req_hs, rsp_acc})
            2'b10:   inflight_nxt = inflight + 2'd1;
            2'b01:   inflight_nxt = inflight - 2'd1;
            default: inflight_nxt = inflight;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            fpc      <= RST_PC;
            rsp_pc   <= RST_PC;
            inflight <= 2'd0;
            drop     <= 2'd0;
        end else begin
            state_q  <= state_d;
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                // Everything still outstanding after this edge belongs to the old path.
                fpc    <= redirect_pc;
                rsp_pc <= redirect_pc;
                drop   <= inflight_nxt;
            end else begin
                if (req_hs) begin
                    fpc <= fpc + 1'b1;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 1'b1;
                end
                if (rsp_acc && (drop != 2'd0)) begin
                    drop <= drop - 2'd1;
                end
            end
        end
    end

    fetch_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({imem_rsp_data, rsp_pc}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
